// File: rtl/bitmap_frame_pkg.sv
// Shared definitions for the bitmap frame packer: sync bytes, FSM encoding, row sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bitmap_frame_pkg;

    localparam logic [7:0] FRAME_SYNC0 = 8'hAA;
    localparam logic [7:0] FRAME_SYNC1 = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_LOAD = 3'd3,
        ST_SEND = 3'd4,
        ST_CSUM = 3'd5
    } state_t;

    // Bytes per bitmap row: 2 bits per cell, 8 bits per byte.
    function automatic int bpr_f(input int area_col);
        return (area_col * 2) / 8;
    endfunction

    // Width of the byte index within a row; never narrower than 1 bit.
    function automatic int idx_w_f(input int bpr);
        return (bpr <= 1) ? 1 : $clog2(bpr);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame rate divider: emits a 1-cycle tick every CLK_FREQ/FRAME_HZ cycles.
// Latency: tick is high during the last count of each period (combinational from the counter).
// Backpressure: none; ticks are free-running.
// Ports: clk (system clock), rstn (sync active-low reset), tick (1-cycle pulse at counter wrap).
module frame_tick_gen #(
    parameter logic [31:0] CLK_FREQ = 32'd50_000_000,
    parameter int          FRAME_HZ = 10
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);

    localparam logic [31:0] PERIOD = CLK_FREQ / 32'(FRAME_HZ);

    logic [31:0] r_cnt;
    logic        w_wrap;

    assign w_wrap = (r_cnt == PERIOD - 32'd1);
    assign tick   = w_wrap;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/bitmap_frame_packer.sv
// Walks the playfield bitmap once per frame tick and streams AA 55, row bytes (MSB first), XOR checksum.
// Latency: first byte valid 1 cycle after the tick; each row costs 2 load cycles before its bytes.
// Backpressure: tx_valid/tx_ready; bytes held stable while stalled; ticks arriving while busy set overrun.
// Ports: clk/rstn (sync active-low), bitmap_row/bitmap_data (1-cycle read channel),
//        tx_data/tx_valid/tx_ready (byte stream), busy (frame in progress), overrun (sticky dropped tick).
module bitmap_frame_packer
    import bitmap_frame_pkg::*;
#(
    parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
    parameter int          FRAME_HZ   = 10,
    parameter int          AREA_ROW   = 32,
    parameter int          AREA_COL   = 16,
    parameter int          ROW_ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic [ROW_ADDR_W-1:0]   bitmap_row,
    input  logic [AREA_COL*2-1:0]   bitmap_data,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    overrun
);

    localparam int ROW_W = AREA_COL * 2;
    localparam int BPR   = bpr_f(AREA_COL);
    localparam int IDX_W = idx_w_f(BPR);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BPR - 1);
    localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(AREA_ROW - 1);

    state_t                  r_state;
    logic [ROW_ADDR_W-1:0]   r_row;
    logic [ROW_W-1:0]        r_shreg;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_csum;
    logic [7:0]              r_tx_data;
    logic                    r_tx_valid;
    logic                    r_busy;
    logic                    r_overrun;
    // LOAD phase: 0 = row address just presented, 1 = bitmap_data now holds that row.
    logic                    r_load_ph;

    logic                    w_tick;
    logic                    w_accept;
    logic [ROW_W-1:0]        w_shifted;

    frame_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .FRAME_HZ (FRAME_HZ)
    ) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .tick (w_tick)
    );

    assign w_accept  = r_tx_valid & tx_ready;
    assign w_shifted = r_shreg << 8;

    assign bitmap_row = r_row;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_shreg    <= '0;
            r_idx      <= '0;
            r_csum     <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_load_ph  <= 1'b0;
        end else begin
            // A tick during a frame (including the CSUM accept cycle) is dropped.
            if (w_tick && r_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state    <= ST_HDR0;
                        r_busy     <= 1'b1;
                        r_csum     <= 8'h00;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= FRAME_SYNC0;
                    end
                end

                ST_HDR0: begin
                    if (w_accept) begin
                        r_tx_data <= FRAME_SYNC1;
                        r_state   <= ST_HDR1;
                    end
                end

                ST_HDR1: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_row      <= '0;
                        r_load_ph  <= 1'b0;
                        r_state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (!r_load_ph) begin
                        r_load_ph <= 1'b1;
                    end else begin
                        r_shreg    <= bitmap_data;
                        r_tx_data  <= bitmap_data[ROW_W-1 -: 8];
                        r_tx_valid <= 1'b1;
                        r_idx      <= '0;
                        r_state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ r_tx_data;
                        if (r_idx != LAST_IDX) begin
                            r_shreg   <= w_shifted;
                            r_tx_data <= w_shifted[ROW_W-1 -: 8];
                            r_idx     <= r_idx + 1'b1;
                        end else if (r_row == LAST_ROW) begin
                            // Fold the final payload byte in directly so CSUM is ready next cycle.
                            r_tx_data <= r_csum ^ r_tx_data;
                            r_state   <= ST_CSUM;
                        end else begin
                            r_row      <= r_row + 1'b1;
                            r_tx_valid <= 1'b0;
                            r_load_ph  <= 1'b0;
                            r_state    <= ST_LOAD;
                        end
                    end
                end

                ST_CSUM: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
